// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
//
// This block generates the PC for each fetch. It keeps one request outstanding
// to the Icache or Memory Controller. Each returned instruction is stored in a
// DEPTH-entry FIFO together with its address and the branch-predictor bit, and
// the Decoder pops entries from that FIFO. Before the PC moves on, the returned
// word is predecoded: JAL, predicted-taken branches and (when C_EXT=1) C.J/C.JAL
// and C.BEQZ/C.BNEZ redirect the next fetch. A flush from the ROB clears the
// FIFO, retargets the PC and drops the response that was still in flight.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   rdy                global enable; low freezes every register
//   flush              redirect from ROB, target on rob_correct_pc
//   bp_pred            taken-prediction for the current fet_pc
//   icache_ready/inst  Icache response (wins over the memory path)
//   mem_inst_ready/inst Memory Controller response
//   dec_ready          Decoder takes the head entry this cycle
//   fet_icache_enable  request outstanding, fet_pc is its address
//   fq_valid/inst/inst_addr/jump_pred  FIFO head view
//   fq_count           occupied FIFO entries
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int C_EXT = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic [XLEN-1:0]          rob_correct_pc,
  input  logic                     bp_pred,
  input  logic                     icache_ready,
  input  logic [XLEN-1:0]          icache_inst,
  input  logic                     mem_inst_ready,
  input  logic [XLEN-1:0]          mem_inst,
  input  logic                     dec_ready,
  output logic                     fet_icache_enable,
  output logic [XLEN-1:0]          fet_pc,
  output logic                     fq_valid,
  output logic [XLEN-1:0]          fq_inst,
  output logic [XLEN-1:0]          fq_inst_addr,
  output logic                     fq_jump_pred,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} state_t;

  state_t          state;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [XLEN-1:0] inst_q [DEPTH];
  logic [XLEN-1:0] addr_q [DEPTH];
  logic            pred_q [DEPTH];

  logic            resp_v;
  logic [XLEN-1:0] resp_inst;
  logic            push;
  logic            pop;
  logic            space;
  logic [XLEN-1:0] pc_next;

  // Immediates, sign-extended to XLEN.
  function automatic logic signed [XLEN-1:0] imm_j(input logic [XLEN-1:0] i);
    return {{(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_b(input logic [XLEN-1:0] i);
    return {{(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_cj(input logic [XLEN-1:0] i);
    return {{(XLEN-11){i[12]}}, i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 1'b0};
  endfunction

  function automatic logic signed [XLEN-1:0] imm_cb(input logic [XLEN-1:0] i);
    return {{(XLEN-8){i[12]}}, i[6:5], i[2], i[11:10], i[4:3], 1'b0};
  endfunction

  // Predecode: the PC advance for the returned word. The sum wraps modulo 2^XLEN.
  // Compressed branches are always redirected. Only 32-bit branches are gated
  // by the predictor.
  function automatic logic [XLEN-1:0] calc_next_pc(input logic [XLEN-1:0] pc,
                                                   input logic [XLEN-1:0] inst,
                                                   input logic            pred);
    logic [XLEN-1:0] step;
    step = XLEN'(4);
    if (inst[1:0] == 2'b11) begin
      if (inst[6:0] == OP_JAL)
        step = $unsigned(imm_j(inst));
      else if (inst[6:0] == OP_BRANCH && pred)
        step = $unsigned(imm_b(inst));
    end else if (C_EXT != 0) begin
      if (inst[1:0] == 2'b01 && inst[14:13] == 2'b01)
        step = $unsigned(imm_cj(inst));
      else if (inst[1:0] == 2'b01 && inst[15:14] == 2'b11)
        step = $unsigned(imm_cb(inst));
      else
        step = XLEN'(2);
    end
    return pc + step;
  endfunction

  assign resp_v    = icache_ready | mem_inst_ready;
  assign resp_inst = icache_ready ? icache_inst : mem_inst;
  assign pc_next   = calc_next_pc(fet_pc, resp_inst, bp_pred);

  assign fq_valid  = (fq_count != '0);
  // A flush has priority, so it blocks push and pop in the same cycle.
  assign push      = rdy & ~flush & (state == WAIT) & resp_v;
  assign pop       = rdy & ~flush & fq_valid & dec_ready;
  // The slot is reserved when the request is issued. A pop in the same cycle
  // frees a slot, so a full FIFO can still issue.
  assign space     = (fq_count != CW'(DEPTH)) | pop;

  // Head view. It is zeroed while empty, so these outputs read 0 out of reset.
  assign fq_inst      = fq_valid ? inst_q[rd_ptr] : '0;
  assign fq_inst_addr = fq_valid ? addr_q[rd_ptr] : '0;
  assign fq_jump_pred = fq_valid & pred_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ISSUE;
      fet_pc            <= RESET_PC;
      fet_icache_enable <= 1'b0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fq_count          <= '0;
    end else if (rdy) begin
      if (flush) begin
        fet_pc   <= rob_correct_pc;
        rd_ptr   <= wr_ptr;
        fq_count <= '0;
        // A request is still in flight and nothing came back this cycle.
        // Keep enable high and wait in DISCARD to swallow the stale reply.
        // DISCARD is included here so that a second flush cannot leave an
        // orphaned response behind.
        if (state != ISSUE && !resp_v) begin
          state             <= DISCARD;
          fet_icache_enable <= 1'b1;
        end else begin
          state             <= ISSUE;
          fet_icache_enable <= 1'b0;
        end
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)
          fq_count <= fq_count + CW'(1);
        else if (pop && !push)
          fq_count <= fq_count - CW'(1);

        case (state)
          ISSUE: begin
            if (space) begin
              fet_icache_enable <= 1'b1;
              state             <= WAIT;
            end else begin
              fet_icache_enable <= 1'b0;
            end
          end
          WAIT: begin
            if (resp_v) begin
              fet_pc            <= pc_next;
              fet_icache_enable <= 1'b0;
              state             <= ISSUE;
            end
          end
          DISCARD: begin
            if (resp_v) begin
              fet_icache_enable <= 1'b0;
              state             <= ISSUE;
            end
          end
          default: begin
            fet_icache_enable <= 1'b0;
            state             <= ISSUE;
          end
        endcase
      end
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr] <= resp_inst;
      addr_q[wr_ptr] <= fet_pc;
      pred_q[wr_ptr] <= bp_pred;
    end
  end

endmodule
